// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART with an independent transmitter and 16x-style receiver.
// Define UART_PARITY_EN to compile in a parity bit (odd/even via parity_odd) on both paths.
module uart_core_param #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 newd,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 busytx,
  output logic                 donetx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 donerx,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_MAX   = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_MAX    = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
    $error("uart_core_param: illegal parameter set");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_e;
`endif

  tx_state_e            tx_state_q, tx_state_d;
  logic [DW-1:0]        tx_div_q, tx_div_d;
  logic [OW-1:0]        tx_os_q, tx_os_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 donetx_q, donetx_d;
  logic                 tx_tick, tx_bit_end, tx_launch;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_tick    = (tx_div_q == DIV_MAX);
  assign tx_bit_end = tx_tick && (tx_os_q == OS_MAX);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_tick ? '0 : tx_div_q + 1'b1;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    busy_d     = (tx_state_q != TX_IDLE);
    donetx_d   = 1'b0;
    tx_launch  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_tick) begin
      tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
    end
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_div_d  = '0;
        tx_os_d   = '0;
        tx_launch = newd;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_data_d = tx_data_q >> 1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LAST_STOP) begin
            // a held request chains straight into the next start bit
            donetx_d   = 1'b1;
            busy_d     = newd;
            tx_launch  = newd;
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_launch) begin
      tx_state_d = TX_START;
      tx_data_d  = din;
      tx_bit_d   = '0;
      tx_div_d   = '0;
      tx_os_d    = '0;
`ifdef UART_PARITY_EN
      tx_par_d   = (^din) ^ parity_odd;
`endif
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (tx_state_q)
      TX_IDLE:   tx_d = 1'b1;
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_data_q[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_d = tx_par_q;
`endif
      TX_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      donetx_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      donetx_q   <= donetx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx     = tx_q;
  assign busytx = busy_q;
  assign donetx = donetx_q;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q;
  logic [DW-1:0]        rx_div_q, rx_div_d;
  logic [OW-1:0]        rx_os_q, rx_os_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 donerx_q, donerx_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_tick, rx_samp;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
  logic                 perr_q, perr_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign rx_tick = (rx_div_q == DIV_MAX);
  assign rx_samp = rx_tick && (rx_os_q == OS_MAX);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    dout_d     = dout_q;
    ferr_d     = ferr_q;
    donerx_d   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    perr_d     = perr_q;
`endif
    if (rx_tick) begin
      rx_os_d = (rx_os_q == OS_MAX) ? '0 : rx_os_q + 1'b1;
    end
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_div_d = '0;
        rx_os_d  = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // realign the phase so later samples land mid-bit
        if (rx_tick && rx_os_q == OS_HALF) begin
          rx_os_d    = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_samp) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_DATA) begin
            rx_bit_d   = '0;
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_samp) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_samp) begin
          dout_d     = rx_sh_q;
          ferr_d     = ~rx_s2_q;
          donerx_d   = 1'b1;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_BREAK;
`ifdef UART_PARITY_EN
          perr_d     = rx_par_q != ((^rx_sh_q) ^ parity_odd);
`endif
        end
      end
      RX_BREAK: begin
        rx_div_d = '0;
        rx_os_d  = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      dout_q     <= '0;
      donerx_q   <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      dout_q     <= dout_d;
      donerx_q   <= donerx_d;
      ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign donerx    = donerx_q;
  assign frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at default parameters (Tb = 96 clocks).
// Parity steps are included when UART_PARITY_EN is defined.
module tb_uart_core_param;

`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int TB = 96;
  localparam int NB = 10 + P;
  localparam int F  = NB * TB;

  logic       clk = 1'b0;
  logic       rst, rx, rx_drv, loop, newd, parity_odd;
  logic [7:0] din, dout;
  logic       tx, busytx, donetx, donerx, frame_err, parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntx = 0;
  int nrx = 0;
  int tdone = 0;
  logic tbusy = 1'b0;
  logic [7:0] rdata = '0;
  logic rferr = 1'b0;
  logic rperr = 1'b0;

  assign rx = loop ? tx : rx_drv;

  uart_core_param dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .din       (din),
    .newd      (newd),
    .parity_odd(parity_odd),
    .tx        (tx),
    .busytx    (busytx),
    .donetx    (donetx),
    .dout      (dout),
    .donerx    (donerx),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (donetx) begin
      ntx   <= ntx + 1;
      tdone <= cyc;
      tbusy <= busytx;
    end
    if (donerx) begin
      nrx   <= nrx + 1;
      rdata <= dout;
      rferr <= frame_err;
      rperr <= parity_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int prev, input int lim);
    int k;
    k = 0;
    while (ntx == prev && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("donetx_timeout", 32'(ntx > prev), 1);
  endtask

  task automatic wait_rx(input int prev, input int lim);
    int k;
    k = 0;
    while (nrx == prev && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("donerx_timeout", 32'(nrx > prev), 1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par,
                         input logic stopv);
    rx_drv = 1'b0;
    repeat (TB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (TB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = par;
    repeat (TB) @(negedge clk);
`else
    if (par === 1'bx) rx_drv = 1'b1;
`endif
    rx_drv = stopv;
    repeat (TB) @(negedge clk);
  endtask

  initial begin
    int n0, t1, p, q;
    logic [7:0] v;
    logic [10:0] eb;

    rst = 1'b1; loop = 1'b0; rx_drv = 1'b1;
    newd = 1'b0; din = '0; parity_odd = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busytx", busytx, 0);
    chk("rst_donetx", donetx, 0);
    chk("rst_dout", dout, 0);
    chk("rst_donerx", donerx, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    @(negedge clk) rst = 1'b0;

    // TX format, 0xA5, one-cycle request
    repeat (5) @(posedge clk);
    #1;
    v = 8'hA5;
    newd = 1'b1; din = v;
    @(posedge clk);
    #1;
    newd = 1'b0; din = 8'hFF;
    n0 = cyc;
    chk("launch_tx_edgeN", tx, 1);
    chk("launch_busy_edgeN", busytx, 0);
    @(posedge clk);
    #1;
    chk("launch_tx_edgeN1", tx, 0);
    chk("launch_busy_edgeN1", busytx, 1);
    eb = '1;
    eb[0] = 1'b0;
    for (int i = 0; i < 8; i++) eb[i+1] = v[i];
`ifdef UART_PARITY_EN
    eb[9] = ^v;
`endif
    eb[NB-1] = 1'b1;
    repeat (TB/2 - 1) @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("txbit%0d", k), tx, eb[k]);
      if (k < NB - 1) begin
        repeat (TB) @(posedge clk);
        #1;
      end
    end
    wait_tx(0, 300);
    chk("donetx_cycle", tdone - n0, F);
    chk("busy_at_done", tbusy, 0);
    #1;
    chk("donetx_single", donetx, 0);
    chk("tx_idle_after", tx, 1);

    // loopback, back-to-back 0x3C then 0xC3
    @(negedge clk);
    loop = 1'b1; din = 8'h3C; newd = 1'b1;
    repeat (20) @(negedge clk);
    din = 8'hC3;
    p = nrx; q = ntx;
    wait_rx(p, 1200);
    chk("lb0_dout", rdata, 8'h3C);
    chk("lb0_ferr", rferr, 0);
    chk("lb0_perr", rperr, 0);
    wait_tx(q, 300);
    t1 = tdone;
    repeat (5) @(negedge clk);
    newd = 1'b0;
    wait_rx(p + 1, 1200);
    chk("lb1_dout", rdata, 8'hC3);
    chk("lb1_ferr", rferr, 0);
    chk("lb1_perr", rperr, 0);
    wait_tx(q + 1, 1200);
    chk("b2b_gap", tdone - t1, F);
    #1;
    chk("b2b_busy_end", busytx, 0);
    @(negedge clk) loop = 1'b0;
    repeat (50) @(negedge clk);

    // framing error, held break, then a clean frame
    p = nrx;
    send_rx(8'h55, ^8'h55, 1'b0);
    chk("fe_count", nrx, p + 1);
    chk("fe_dout", rdata, 8'h55);
    chk("fe_flag", rferr, 1);
    repeat (1200) @(negedge clk);
    chk("fe_break_hold", nrx, p + 1);
    chk("fe_flag_held", frame_err, 1);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    send_rx(8'h12, ^8'h12, 1'b1);
    repeat (4) @(negedge clk);
    chk("fe_next_count", nrx, p + 2);
    chk("fe_next_dout", rdata, 8'h12);
    chk("fe_cleared", frame_err, 0);

    // false start of 32 clocks
    p = nrx;
    rx_drv = 1'b0;
    repeat (32) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("false_start", nrx, p);
    send_rx(8'h81, ^8'h81, 1'b1);
    repeat (4) @(negedge clk);
    chk("fs_next_count", nrx, p + 1);
    chk("fs_next_dout", rdata, 8'h81);
    chk("fs_next_ferr", rferr, 0);

`ifdef UART_PARITY_EN
    // parity bit on tx for 0x07 (even) and rx parity checking
    @(posedge clk);
    #1;
    newd = 1'b1; din = 8'h07;
    @(posedge clk);
    #1;
    newd = 1'b0;
    q = ntx;
    repeat (TB/2 + 9 * TB) @(posedge clk);
    #1;
    chk("tx_parity_bit", tx, 1);
    wait_tx(q, 300);
    repeat (20) @(negedge clk);
    p = nrx;
    send_rx(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("perr_count", nrx, p + 1);
    chk("perr_dout", rdata, 8'h07);
    chk("perr_flag", rperr, 1);
    parity_odd = 1'b1;
    send_rx(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("podd_flag", rperr, 0);
    parity_odd = 1'b0;
`endif

    // reset mid-frame on both directions
    @(negedge clk);
    din = 8'h5A; newd = 1'b1; rx_drv = 1'b0;
    @(negedge clk) newd = 1'b0;
    repeat (398) @(negedge clk);
    p = nrx; q = ntx;
    rst = 1'b1; rx_drv = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busytx, 0);
    chk("mid_rst_donetx", donetx, 0);
    chk("mid_rst_donerx", donerx, 0);
    chk("mid_rst_dout", dout, 0);
    @(negedge clk) rst = 1'b0;
    repeat (1200) @(negedge clk);
    chk("mid_rst_no_tx", ntx, q);
    chk("mid_rst_no_rx", nrx, p);
    loop = 1'b1; din = 8'hF0; newd = 1'b1;
    @(negedge clk) newd = 1'b0;
    wait_rx(p, 1200);
    chk("post_rst_dout", rdata, 8'hF0);
    chk("post_rst_ferr", rferr, 0);
    wait_tx(q, 300);
    #1;
    chk("post_rst_busy", busytx, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised full-duplex UART core, the next generation of the team's fixed 8N1 UART top. It provides a transmitter and a 16x-oversampled receiver sharing one clock and reset. Data width, stop-bit count and oversampling ratio are configurable, and an optional parity bit can be compiled in. The receiver reports framing and parity errors. The core sits between a byte/word-level host interface and the serial pins.

## Interface
- `CLK_FREQ`, default 1000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `STOP_BITS`, default 1: stop bits, 1 or 2.
- `OVERSAMPLE`, default 16: ticks per bit, even, at least 4.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: serial input, asynchronous, idles high.
- `din`, in, DATA_BITS: word to transmit.
- `newd`, in, 1: transmit request, level-sensitive.
- `parity_odd`, in, 1: 1 selects odd parity, 0 selects even. Ignored when parity is compiled out.
- `tx`, out, 1: serial output, idles high.
- `busytx`, out, 1: transmitter is mid-frame.
- `donetx`, out, 1: one-cycle pulse at the end of a frame.
- `dout`, out, DATA_BITS: last received word.
- `donerx`, out, 1: one-cycle pulse when `dout` updates.
- `frame_err`, out, 1: stop-bit error on the last received word.
- `parity_err`, out, 1: parity error on the last received word. Constant 0 when parity is compiled out.

## Operation
- **Tick divider:** DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer division. DIV < 1 is an elaboration error. TX and RX each have an independent divider.
- **Frame format:** start(0), DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits(1).
- **TX states:** IDLE → START → DATA → [PARITY] → STOP → IDLE. Each bit is held for OVERSAMPLE ticks.
- **TX launch:** in IDLE, if `newd` is 1, the core latches `din`, restarts the TX divider and enters START.
- **TX end of frame:** at the end of the final stop bit, `donetx` pulses and the FSM returns to IDLE.
- **TX back-to-back:** if `newd` is still 1 in IDLE, the next frame starts with no idle gap.
- **TX input stability:** `din` changes during a frame do not affect that frame.
- **RX synchroniser:** `rx` passes through a 2-flop synchroniser, reset value 1.
- **RX states:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **RX start detect:** in IDLE, a synchronised 0 restarts the RX divider.
- **RX start qualify:** START waits OVERSAMPLE/2 ticks and resamples. If the line is 1, it is a false start and the FSM returns to IDLE with no pulse.
- **RX bit sampling:** each subsequent bit is sampled once, OVERSAMPLE ticks after the previous sample (mid-bit). Only the first stop bit is checked.
- **RX result:** at the stop-bit sample, `dout`, `frame_err` (stop sampled 0) and `parity_err` update together and `donerx` pulses. The error flags hold until the next `donerx`.
- **RX after frame error:** the FSM waits for the line to return to 1 before re-entering IDLE (break handling).
- **Parity:** even parity = XOR of the data bits. Odd parity = its inverse.
- **Simultaneous TX/RX:** TX and RX are fully independent. Concurrent operation is required.

## Timing
- **Reset values:** `tx`=1, `busytx`=0, `donetx`=0, `dout`=0, `donerx`=0, `frame_err`=0, `parity_err`=0. Both FSMs enter IDLE and both dividers clear.
- **Reset mid-frame:** outputs take their reset values on the clock edge where `rst` is sampled high. Any partial RX word is discarded.
- **Bit period:** Tb = OVERSAMPLE*DIV clocks. With defaults, DIV=6 and Tb=96 clocks.
- **TX launch latency:** `newd` sampled high at edge N → `tx`=0 and `busytx`=1 from edge N+1.
- **TX frame length:** F = (1 + DATA_BITS + P + STOP_BITS)*Tb clocks, where P=1 if parity is compiled in, else 0.
- **TX end timing:** `donetx` is high for the single cycle at edge N+F. `busytx` falls on that same edge.
- **RX latency:** `donerx` asserts 2 (synchroniser) + (DATA_BITS + P + 1)*Tb + Tb/2 clocks after the `rx` falling edge, ±1 cycle.

## Configuration
- **Macro:** `UART_PARITY_EN`.
- **Defined:** the PARITY state exists in both FSMs. TX inserts the parity bit selected by `parity_odd`. RX checks the received parity bit and drives `parity_err`.
- **Undefined:** there is no parity bit in either direction. `parity_err` is tied to 0. `parity_odd` is unused.

## Test plan
- **TX format:** defaults, parity off, `din`=0xA5, `newd` pulsed 1 cycle → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 96 clocks. `donetx` pulses 960 clocks after launch. `busytx` falls on the same edge.
- **Loopback, back-to-back:** `tx` wired to `rx`, `newd` held high, words 0x3C then 0xC3 → two `donerx` pulses, `dout` = 0x3C then 0xC3, `frame_err`=`parity_err`=0. No idle gap between TX frames.
- **Parity:** `UART_PARITY_EN` defined, `parity_odd`=0, `din`=0x07 → parity bit 1 on `tx`. Injected frame 0x07 with parity 0 → `donerx` with `parity_err`=1 and `dout`=0x07.
- **Framing error:** injected frame 0x55 with stop bit driven 0 → `donerx`, `dout`=0x55, `frame_err`=1. No new frame is detected until `rx` returns high. The next clean frame 0x12 clears `frame_err`.
- **False start:** `rx` pulled low for 32 clocks (less than Tb/2=48) → no `donerx` pulse. RX FSM is back in IDLE and then receives 0x81 correctly.
- **Reset mid-frame:** `rst` asserted 400 clocks into a TX frame and an RX frame → next edge: `tx`=1, `busytx`=0, no `donetx`/`donerx` pulses. A fresh 0xF0 transfer after release completes normally.
